// File: rtl/demux_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : demux_bus_pkg
//  Description : Shared constants and types for the registered 1:N bus
//                demultiplexer and its per-channel register slices.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_bus_pkg;

    // Default geometry: 3-bit words steered to 16 channels by a 4-bit select
    localparam int DEF_DATA_W = 3;
    localparam int DEF_SEL_W  = 4;
    localparam int DEF_N_OUT  = 16;

    // Dropped-word counter saturates instead of wrapping
    localparam int                     DROP_CNT_W   = 8;
    localparam logic [DROP_CNT_W-1:0]  DROP_CNT_MAX = '1;

    typedef logic [DEF_DATA_W-1:0] data_t;

endpackage : demux_bus_pkg
`default_nettype wire

// File: rtl/demux_chan_reg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_chan_reg
//  Description : One-entry holding register for a single output channel.
//                A load always wins over a drain, so a channel that is
//                emptied and refilled on the same edge stays valid and
//                sustains one word per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_chan_reg
    import demux_bus_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic              valid_q;
    logic              valid_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // Next state: load replaces the word, otherwise a handshake empties the slot
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Slot register; data is left untouched on drain so it stays stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule : demux_chan_reg
`default_nettype wire

// File: rtl/demux1x16_bus_reg.sv
`default_nettype none
// ============================================================================
//  Module      : demux1x16_bus_reg
//  Description : Registered 1:N demultiplexer for narrow buses. A single
//                valid/ready source is steered into per-channel holding
//                registers; each channel drains on its own handshake, so a
//                stalled consumer only back-pressures words addressed to it.
//                Out-of-range selects are accepted, discarded, flagged with
//                a one-cycle error pulse and counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux1x16_bus_reg
    import demux_bus_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SEL_W  = DEF_SEL_W,
    parameter int N_OUT  = DEF_N_OUT     // legal range 2 .. 2**SEL_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [DATA_W-1:0]       in_data,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic                    sel_err,
    output logic [DROP_CNT_W-1:0]   drop_cnt
);

    logic [N_OUT-1:0]      w_hit;
    logic [N_OUT-1:0]      w_load;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_in_range;
    logic                  w_drop;

    logic                  sel_err_q;
    logic                  sel_err_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q;
    logic [DROP_CNT_W-1:0] drop_cnt_d;

    // One-hot decode of the select; all-zero means the select is out of range
    generate
        for (genvar k = 0; k < N_OUT; k++) begin : g_chan
            assign w_hit[k]  = (in_sel == SEL_W'(k));
            assign w_load[k] = w_accept && w_hit[k];

            demux_chan_reg #(
                .DATA_W (DATA_W)
            ) u_chan (
                .clk       (clk),
                .rst_n     (rst_n),
                .load      (w_load[k]),
                .load_data (in_data),
                .out_ready (out_ready[k]),
                .out_valid (out_valid[k]),
                .out_data  (out_data[k*DATA_W +: DATA_W])
            );
        end
    endgenerate

    assign w_in_range = |w_hit;
    assign w_accept   = in_valid && w_ready;
    assign w_drop     = w_accept && !w_in_range;

    // Ready looks only at the addressed slot; unknown destinations always sink
    always_comb begin
        w_ready = 1'b1;
        for (int k = 0; k < N_OUT; k++) begin
            if (w_hit[k]) begin
                w_ready = !out_valid[k] || out_ready[k];
            end
        end
    end

    assign in_ready = w_ready;

    // Error pulse follows each discarded word; drop counter sticks at its max
    always_comb begin
        sel_err_d  = w_drop;
        drop_cnt_d = drop_cnt_q;
        if (w_drop && (drop_cnt_q != DROP_CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // Error flag and drop counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            sel_err_q  <= sel_err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign sel_err  = sel_err_q;
    assign drop_cnt = drop_cnt_q;

endmodule : demux1x16_bus_reg
`default_nettype wire

// File: tb/tb_demux1x16_bus_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux1x16_bus_reg
//  Description : Directed bench for the registered 1:N bus demultiplexer,
//                built with 12 channels so out-of-range selects exist,
//                followed by a random traffic phase against a channel model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux1x16_bus_reg;

    localparam int DW = 3;
    localparam int SW = 4;
    localparam int NO = 12;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [SW-1:0]    in_sel;
    logic [DW-1:0]    in_data;
    logic [NO-1:0]    out_valid;
    logic [NO-1:0]    out_ready;
    logic [NO*DW-1:0] out_data;
    logic             sel_err;
    logic [7:0]       drop_cnt;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    demux1x16_bus_reg #(
        .DATA_W (DW),
        .SEL_W  (SW),
        .N_OUT  (NO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sel_err   (sel_err),
        .drop_cnt  (drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] chan(input int k);
        return out_data[k*DW +: DW];
    endfunction

    // random-phase model state
    logic          mv [NO];
    logic [DW-1:0] md [NO];
    logic [NO-1:0] mvv;
    logic          e_rdy, acc, e_err, hold;
    int            e_drop, sent, recv, resid;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data",  64'(out_data),  64'h0);
        chk("rst_sel_err",   64'(sel_err),   64'h0);
        chk("rst_drop_cnt",  64'(drop_cnt),  64'h0);
        rst_n = 1'b1;
        step();

        // single route to channel 5
        in_valid = 1'b1; in_sel = 4'd5; in_data = 3'b101; #1;
        chk("route_in_ready", 64'(in_ready), 64'h1);
        step();
        in_valid = 1'b0;
        chk("route_valid",  64'(out_valid), 64'h020);
        chk("route_data5",  64'(chan(5)),   64'h5);
        step();
        chk("route_hold",   64'(out_valid), 64'h020);
        out_ready[5] = 1'b1;
        step();
        out_ready[5] = 1'b0;
        chk("route_drain",  64'(out_valid), 64'h000);
        chk("route_retain", 64'(chan(5)),   64'h5);

        // back-pressure isolation
        in_valid = 1'b1; in_sel = 4'd2; in_data = 3'd4;
        step();
        in_data = 3'd1; #1;
        chk("bp_in_ready_ch2", 64'(in_ready), 64'h0);
        step();
        chk("bp_ch2_kept",     64'(chan(2)),   64'h4);
        chk("bp_valid_ch2",    64'(out_valid), 64'h004);
        in_sel = 4'd9; in_data = 3'b011; #1;
        chk("bp_in_ready_ch9", 64'(in_ready), 64'h1);
        step();
        in_valid = 1'b0;
        chk("bp_valid_ch9",    64'(out_valid), 64'h204);
        chk("bp_data_ch9",     64'(chan(9)),   64'h3);

        // full throughput on channel 7
        out_ready[7] = 1'b1;
        for (int d = 1; d <= 4; d++) begin
            in_valid = 1'b1; in_sel = 4'd7; in_data = DW'(d); #1;
            chk("tp_in_ready", 64'(in_ready), 64'h1);
            step();
            chk("tp_valid7", 64'(out_valid[7]), 64'h1);
            chk("tp_data7",  64'(chan(7)),      64'(d));
        end
        in_valid = 1'b0;
        step();
        out_ready[7] = 1'b0;
        chk("tp_drained", 64'(out_valid), 64'h204);

        // out-of-range select
        in_valid = 1'b1; in_sel = 4'd13; in_data = 3'd6; #1;
        chk("oor_in_ready", 64'(in_ready), 64'h1);
        step();
        in_valid = 1'b0;
        chk("oor_valid",    64'(out_valid), 64'h204);
        chk("oor_sel_err",  64'(sel_err),   64'h1);
        chk("oor_drop_cnt", 64'(drop_cnt),  64'h1);
        step();
        chk("oor_err_pulse", 64'(sel_err), 64'h0);
        in_valid = 1'b1; in_sel = 4'd13;
        for (int i = 0; i < 300; i++) begin
            step();
            chk("sat_sel_err",  64'(sel_err),  64'h1);
            chk("sat_drop_cnt", 64'(drop_cnt), 64'((i + 2 > 255) ? 255 : i + 2));
        end
        in_valid = 1'b0;
        step();
        chk("sat_err_low", 64'(sel_err),  64'h0);
        chk("sat_final",   64'(drop_cnt), 64'd255);

        // asynchronous reset mid-cycle with channel 3 full
        in_valid = 1'b1; in_sel = 4'd3; in_data = 3'd7;
        step();
        in_valid = 1'b0;
        chk("arst_ch3_full", 64'(out_valid), 64'h20c);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid",    64'(out_valid), 64'h0);
        chk("arst_data",     64'(out_data),  64'h0);
        chk("arst_sel_err",  64'(sel_err),   64'h0);
        chk("arst_drop_cnt", 64'(drop_cnt),  64'h0);
        step();
        rst_n = 1'b1;

        // random traffic against a per-channel model
        for (int k = 0; k < NO; k++) begin
            mv[k] = 1'b0; md[k] = '0;
        end
        e_drop = 0; sent = 0; recv = 0; hold = 1'b0;
        for (int c = 0; c < 500; c++) begin
            out_ready = NO'($urandom);
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = SW'($urandom_range(0, 15));
                in_data  = DW'($urandom);
            end
            #1;
            e_rdy = (int'(in_sel) < NO) ? (!mv[in_sel] || out_ready[in_sel]) : 1'b1;
            chk("rnd_in_ready", 64'(in_ready), 64'(e_rdy));
            acc = in_valid && e_rdy;
            for (int k = 0; k < NO; k++) begin
                if (mv[k] && out_ready[k]) recv++;
                if (acc && int'(in_sel) == k) begin
                    mv[k] = 1'b1; md[k] = in_data; sent++;
                end else if (mv[k] && out_ready[k]) begin
                    mv[k] = 1'b0;
                end
            end
            e_err = acc && (int'(in_sel) >= NO);
            if (e_err && e_drop < 255) e_drop++;
            hold = in_valid && !acc;
            step();
            for (int k = 0; k < NO; k++) mvv[k] = mv[k];
            chk("rnd_out_valid", 64'(out_valid), 64'(mvv));
            for (int k = 0; k < NO; k++) begin
                if (mv[k]) chk("rnd_out_data", 64'(chan(k)), 64'(md[k]));
            end
            chk("rnd_sel_err",  64'(sel_err),  64'(e_err));
            chk("rnd_drop_cnt", 64'(drop_cnt), 64'(e_drop));
        end
        resid = 0;
        for (int k = 0; k < NO; k++) if (mv[k]) resid++;
        chk("rnd_conservation", 64'(sent), 64'(recv + resid));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_demux1x16_bus_reg
`default_nettype wire
